alu_cmd_seq: RTL and testbench
==============================

Name: alu_cmd_seq

Overview:
Upstream command sequencer for the registered ALU. Buffers operation requests from a valid/ready command interface in a small FIFO and issues one at a time to the ALU's A/B/ALU_FUN inputs. Captures ALU_OUT and the four class flags after the ALU's one-cycle register latency, then returns a tagged response on a valid/ready interface. Screens illegal opcodes and divide-by-zero before issue.

Parameters:
IN_DATA_WIDTH, 16, operand width; matches the ALU.
OUT_DATA_WIDTH, 32, result width; matches the ALU.
DEPTH, 4, command FIFO entries; must be a power of 2 and at least 2.
TAG_WIDTH, 4, width of the opaque request tag.

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept a command
cmd_a  in  IN_DATA_WIDTH  operand A
cmd_b  in  IN_DATA_WIDTH  operand B
cmd_fun  in  4  ALU function code
cmd_tag  in  TAG_WIDTH  request tag
alu_a  out  IN_DATA_WIDTH  to ALU A
alu_b  out  IN_DATA_WIDTH  to ALU B
alu_fun  out  4  to ALU ALU_FUN
alu_out  in  OUT_DATA_WIDTH  from ALU ALU_OUT
alu_flags  in  4  {Arith,Logic,CMP,Shift} from the ALU
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts the response
rsp_data  out  OUT_DATA_WIDTH  result
rsp_tag  out  TAG_WIDTH  tag of the completed command
rsp_flags  out  4  class flags captured at issue
rsp_err  out  1  1 = illegal opcode or divide by zero; result not computed
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: cmd_ready=1, FIFO empty, state=IDLE, alu_a=0, alu_b=0, alu_fun=4'b1111, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_flags=0, rsp_err=0, busy=0.
- Reset mid-operation: FIFO is flushed, any in-flight command is dropped and no response is produced for it, and all outputs return to their reset values on the next edge.
- Command interface:
  - A command is accepted on a cycle where cmd_valid && cmd_ready; it is pushed at that edge.
  - cmd_ready = !full, registered-free combinational from the count. There is no bypass.
  - When full, cmd_ready=0 even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - Count width is clog2(DEPTH)+1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head.
  - If fun==4'b1111, or (fun==4'b0011 && b==0): load rsp_err=1, rsp_data=0, rsp_flags=0, rsp_tag=tag, and go to RESP. alu_fun stays 4'b1111.
  - Otherwise load alu_a, alu_b, alu_fun from the head, hold the tag, and go to ISSUE.
- ISSUE: the operands are stable on the ALU inputs and the ALU registers its result at the end of this cycle. Sample alu_flags into the hold register. Go to WAIT.
- WAIT:
  - alu_out is valid; capture it into rsp_data, set rsp_err=0, and move the flags and tag to the rsp registers.
  - Drive alu_fun=4'b1111 (operands hold their last value).
  - Go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data, rsp_tag, rsp_flags and rsp_err are held stable until rsp_valid && rsp_ready.
  - On the handshake, go to IDLE with rsp_valid=0 on the next cycle.
  - Back-pressure on rsp_ready stalls the FSM only; the FIFO keeps accepting commands until full.
- Latency (empty FIFO, rsp_ready=1, command accepted in cycle T):
  - Legal command: IDLE pop in T+1, ISSUE in T+2, WAIT in T+3, rsp_valid in T+4.
  - Error command: rsp_valid in T+2.
  - Steady-state throughput is 1 command per 4 cycles.
- Ordering: responses are returned strictly in acceptance order.
- busy = (count!=0) || (state!=IDLE).

Decomposition:
- Package alu_pkg holds:
  - Function-code localparams: FUN_ADD=0, FUN_SUB=1, FUN_MUL=2, FUN_DIV=3, … FUN_SHL=14, FUN_NOP=15.
  - FSM state encodings.
  - The flag bit index constants.
- One sub-module is natural: alu_cmd_fifo, a synchronous FIFO of width 2*IN_DATA_WIDTH+4+TAG_WIDTH and depth DEPTH, with push/pop/full/empty/count.

Test Plan:
1. Reset then single ADD: a=3, b=5, fun=0, tag=2, accepted at T → rsp_valid at T+4 with data=8, tag=2, flags=4'b1000, err=0. alu_fun returns to 15 afterwards.
2. Divide by zero: a=10, b=0, fun=3, tag=7 → rsp_valid at T+2 with err=1, data=0, flags=0. alu_fun is never 3.
3. Fill FIFO: back-to-back pushes with rsp_ready=0 → cmd_ready drops after DEPTH+1 accepts (one command in the FSM). Releasing rsp_ready drains the responses in order, with tags 0..4 matching.
4. Compare and shift mix: GT a=9, b=4 → data=2, flags=0010. LT a=1, b=2 → data=3. SHR a=16'h8001 → data=32'h4000, flags=0001. SHL a=16'hFFFF → data=32'h1FFFE.
5. Reset asserted while in WAIT with 2 queued commands → next cycle rsp_valid=0, busy=0, cmd_ready=1. No stale responses afterwards.
6. Simultaneous push and pop at count=DEPTH-1 → count unchanged, cmd_ready stays 1, and the data order is preserved across pointer wrap.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: function codes,
// FSM state encodings and flag bit positions.
package alu_pkg;

  localparam logic [3:0] FUN_ADD  = 4'd0;
  localparam logic [3:0] FUN_SUB  = 4'd1;
  localparam logic [3:0] FUN_MUL  = 4'd2;
  localparam logic [3:0] FUN_DIV  = 4'd3;
  localparam logic [3:0] FUN_AND  = 4'd4;
  localparam logic [3:0] FUN_OR   = 4'd5;
  localparam logic [3:0] FUN_NAND = 4'd6;
  localparam logic [3:0] FUN_NOR  = 4'd7;
  localparam logic [3:0] FUN_XOR  = 4'd8;
  localparam logic [3:0] FUN_XNOR = 4'd9;
  localparam logic [3:0] FUN_EQ   = 4'd10;
  localparam logic [3:0] FUN_GT   = 4'd11;
  localparam logic [3:0] FUN_LT   = 4'd12;
  localparam logic [3:0] FUN_SHR  = 4'd13;
  localparam logic [3:0] FUN_SHL  = 4'd14;
  localparam logic [3:0] FUN_NOP  = 4'd15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Bit positions inside the {Arith,Logic,CMP,Shift} flag vector
  localparam int FLAG_ARITH = 3;
  localparam int FLAG_LOGIC = 2;
  localparam int FLAG_CMP   = 1;
  localparam int FLAG_SHIFT = 0;

  // Commands the ALU must never see: the NOP code and divide by zero
  function automatic logic cmd_is_illegal(input logic [3:0] fun, input logic b_zero);
    return (fun == FUN_NOP) || ((fun == FUN_DIV) && b_zero);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; pointers wrap modulo DEPTH,
// which must be a power of two.
module alu_cmd_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer in front of the registered ALU: queues requests, issues
// them one at a time and returns tagged results in acceptance order.
//
//   state | meaning
//   IDLE  | pop FIFO head; screen illegal ops straight to RESP
//   ISSUE | operands on ALU inputs, ALU registers result this cycle
//   WAIT  | alu_out valid, capture into response registers
//   RESP  | rsp_valid high until consumer handshake
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 32,
  parameter int DEPTH          = 4,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [IN_DATA_WIDTH-1:0]  cmd_a,
  input  logic [IN_DATA_WIDTH-1:0]  cmd_b,
  input  logic [3:0]                cmd_fun,
  input  logic [TAG_WIDTH-1:0]      cmd_tag,
  output logic [IN_DATA_WIDTH-1:0]  alu_a,
  output logic [IN_DATA_WIDTH-1:0]  alu_b,
  output logic [3:0]                alu_fun,
  input  logic [OUT_DATA_WIDTH-1:0] alu_out,
  input  logic [3:0]                alu_flags,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [OUT_DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]      rsp_tag,
  output logic [3:0]                rsp_flags,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int FW    = 2*IN_DATA_WIDTH + 4 + TAG_WIDTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]               state;
  logic [FW-1:0]            head;
  logic                     full;
  logic                     empty;
  logic [CNT_W-1:0]         count;
  logic                     pop;
  logic [IN_DATA_WIDTH-1:0] head_a;
  logic [IN_DATA_WIDTH-1:0] head_b;
  logic [3:0]               head_fun;
  logic [TAG_WIDTH-1:0]     head_tag;
  logic [TAG_WIDTH-1:0]     tag_hold;
  logic [3:0]               flags_hold;

  alu_cmd_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (cmd_valid && cmd_ready),
    .wr_data ({cmd_a, cmd_b, cmd_fun, cmd_tag}),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign head_a   = head[FW-1 -: IN_DATA_WIDTH];
  assign head_b   = head[FW-1-IN_DATA_WIDTH -: IN_DATA_WIDTH];
  assign head_fun = head[TAG_WIDTH +: 4];
  assign head_tag = head[TAG_WIDTH-1:0];

  assign cmd_ready = !full;
  assign pop       = (state == ST_IDLE) && !empty;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (count != '0) || (state != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fun    <= FUN_NOP;
      tag_hold   <= '0;
      flags_hold <= '0;
      rsp_data   <= '0;
      rsp_tag    <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (cmd_is_illegal(head_fun, head_b == '0)) begin
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_flags <= '0;
              rsp_tag   <= head_tag;
              state     <= ST_RESP;
            end else begin
              alu_a    <= head_a;
              alu_b    <= head_b;
              alu_fun  <= head_fun;
              tag_hold <= head_tag;
              state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          flags_hold <= alu_flags;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          rsp_data  <= alu_out;
          rsp_err   <= 1'b0;
          rsp_flags <= flags_hold;
          rsp_tag   <= tag_hold;
          // Park the ALU on NOP; operands keep their last value
          alu_fun   <= FUN_NOP;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq with a behavioural registered ALU and
// a response scoreboard fed at command acceptance.
module tb_alu_cmd_seq;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
    logic [3:0]  flags;
    logic        err;
  } rsp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [3:0]  cmd_fun = '0;
  logic [3:0]  cmd_tag = '0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_fun;
  logic [31:0] alu_out = '0;
  logic [3:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  rsp_t sb[$];

  always #5 CLK = ~CLK;

  alu_cmd_seq dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU: result registered one cycle, class flags combinational
  function automatic logic [31:0] alu_calc(input logic [15:0] a, b, input logic [3:0] f);
    case (f)
      4'd0:  return {16'd0, a} + {16'd0, b};
      4'd1:  return {16'd0, a} - {16'd0, b};
      4'd2:  return {16'd0, a} * {16'd0, b};
      4'd3:  return (b == 0) ? 32'd0 : {16'd0, a / b};
      4'd4:  return {16'd0, a & b};
      4'd5:  return {16'd0, a | b};
      4'd6:  return {16'd0, ~(a & b)};
      4'd7:  return {16'd0, ~(a | b)};
      4'd8:  return {16'd0, a ^ b};
      4'd9:  return {16'd0, ~(a ^ b)};
      4'd10: return (a == b) ? 32'd1 : 32'd0;
      4'd11: return (a > b)  ? 32'd2 : 32'd0;
      4'd12: return (a < b)  ? 32'd3 : 32'd0;
      4'd13: return {16'd0, a >> 1};
      4'd14: return {15'd0, a, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge CLK) alu_out <= alu_calc(alu_a, alu_b, alu_fun);

  always_comb begin
    alu_flags = 4'b0000;
    if (alu_fun <= 4'd3)       alu_flags = 4'b1000;
    else if (alu_fun <= 4'd9)  alu_flags = 4'b0100;
    else if (alu_fun <= 4'd12) alu_flags = 4'b0010;
    else if (alu_fun <= 4'd14) alu_flags = 4'b0001;
  end

  // Monitor: compare every completed response handshake against the scoreboard
  always @(negedge CLK) begin
    rsp_t got;
    rsp_t exp;
    if (!RST && rsp_valid && rsp_ready) begin
      got = '{data: rsp_data, tag: rsp_tag, flags: rsp_flags, err: rsp_err};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got data=%h tag=%h flags=%b err=%b, required none",
                 rsp_data, rsp_tag, rsp_flags, rsp_err);
      end else begin
        exp = sb.pop_front();
        if (got !== exp)
          begin
            errors++;
            $display("FAIL rsp_tag%0h: got data=%h tag=%h flags=%b err=%b, required data=%h tag=%h flags=%b err=%b",
                     exp.tag, got.data, got.tag, got.flags, got.err,
                     exp.data, exp.tag, exp.flags, exp.err);
          end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one command; returns one cycle after the accepting edge
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                      input logic [3:0] tag, input logic [31:0] d, input logic [3:0] fl,
                      input logic er, input bit track);
    bit acc = 1'b0;
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_fun = fun; cmd_tag = tag; cmd_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge CLK);
      acc = cmd_ready;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout tag%0h: got no accept, required accept within 50 cycles", tag);
    end else if (track) begin
      sb.push_back('{data: d, tag: tag, flags: fl, err: er});
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    chk(name, sb.size(), 0);
  endtask

  initial begin
    // Reset state
    RST = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_fun", alu_fun, 15);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    RST = 1'b0;
    tick();

    // 1: single ADD, response at T+4
    send(16'd3, 16'd5, 4'd0, 4'd2, 32'd8, 4'b1000, 1'b0, 1'b1);
    chk("t1_valid_t1", rsp_valid, 0);
    chk("t1_busy_t1", busy, 1);
    tick();
    tick();
    chk("t1_valid_t3", rsp_valid, 0);
    tick();
    chk("t1_valid_t4", rsp_valid, 1);
    chk("t1_alu_fun_nop", alu_fun, 15);
    tick();
    chk("t1_idle_after", busy, 0);

    // 2: divide by zero, response at T+2, ALU never sees DIV
    send(16'd10, 16'd0, 4'd3, 4'd7, 32'd0, 4'b0000, 1'b1, 1'b1);
    chk("t2_valid_t1", rsp_valid, 0);
    chk("t2_no_div_t1", alu_fun != 4'd3, 1);
    tick();
    chk("t2_valid_t2", rsp_valid, 1);
    chk("t2_err_t2", rsp_err, 1);
    chk("t2_alu_fun", alu_fun, 15);
    tick();

    // 3: fill FIFO under back-pressure, then drain in order
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(16'(i), 16'd10, 4'd0, 4'(i), 32'(i + 10), 4'b1000, 1'b0, 1'b1);
    chk("t3_ready_after4", cmd_ready, 1);
    send(16'd4, 16'd10, 4'd0, 4'd4, 32'd14, 4'b1000, 1'b0, 1'b1);
    chk("t3_ready_after5", cmd_ready, 0);
    chk("t3_busy_full", busy, 1);
    repeat (3) tick();
    chk("t3_ready_stalled", cmd_ready, 0);
    rsp_ready = 1'b1;
    drain("t3_drain");

    // 4: compare, shift, logic and illegal opcode mix
    send(16'd9, 16'd4, 4'd11, 4'd3, 32'd2, 4'b0010, 1'b0, 1'b1);
    send(16'd1, 16'd2, 4'd12, 4'd5, 32'd3, 4'b0010, 1'b0, 1'b1);
    send(16'h8001, 16'd0, 4'd13, 4'd6, 32'h4000, 4'b0001, 1'b0, 1'b1);
    send(16'hFFFF, 16'd0, 4'd14, 4'd8, 32'h1FFFE, 4'b0001, 1'b0, 1'b1);
    send(16'd5, 16'd6, 4'd15, 4'd9, 32'd0, 4'b0000, 1'b1, 1'b1);
    send(16'h00F0, 16'h0FF0, 4'd8, 4'd10, 32'h0F00, 4'b0100, 1'b0, 1'b1);
    drain("t4_drain");

    // 5: reset while in WAIT with two queued commands
    send(16'd1, 16'd1, 4'd0, 4'd1, 32'd0, 4'b0, 1'b0, 1'b0);
    send(16'd2, 16'd1, 4'd0, 4'd2, 32'd0, 4'b0, 1'b0, 1'b0);
    send(16'd3, 16'd1, 4'd0, 4'd3, 32'd0, 4'b0, 1'b0, 1'b0);
    chk("t5_busy_pre", busy, 1);
    RST = 1'b1;
    tick();
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cmd_ready", cmd_ready, 1);
    chk("t5_alu_fun", alu_fun, 15);
    chk("t5_rsp_data", rsp_data, 0);
    RST = 1'b0;
    repeat (12) tick();
    chk("t5_no_stale", rsp_valid, 0);

    // 6: simultaneous push and pop at count=DEPTH-1, across pointer wrap
    rsp_ready = 1'b0;
    send(16'd20, 16'd1, 4'd0, 4'd11, 32'd21, 4'b1000, 1'b0, 1'b1);
    send(16'd30, 16'd2, 4'd0, 4'd12, 32'd32, 4'b1000, 1'b0, 1'b1);
    send(16'd40, 16'd3, 4'd0, 4'd13, 32'd43, 4'b1000, 1'b0, 1'b1);
    send(16'd50, 16'd4, 4'd0, 4'd14, 32'd54, 4'b1000, 1'b0, 1'b1);
    repeat (2) tick();
    chk("t6_ready_cnt3", cmd_ready, 1);
    chk("t6_in_resp", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    send(16'd60, 16'd5, 4'd0, 4'd15, 32'd65, 4'b1000, 1'b0, 1'b1);
    chk("t6_ready_pushpop", cmd_ready, 1);
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
